// File: rtl/cora16_sequencer.sv
// cora16 fetch/decode/execute sequencer.
// Owns PC and IR, fetches 1- or 2-byte instructions over a byte-wide
// handshake, fetches/stores the memory operand, then pulses exec for one cycle.
module cora16_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] inst,
    output logic        dec_en,
    output logic [7:0]  data,
    input  logic        dec_halt,
    input  logic        dec_trap,
    input  logic        dec_mem,
    input  logic        dec_store,
    input  logic [15:0] opnd_addr,
    input  logic [7:0]  store_data,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic        exec,
    output logic [15:0] pc,
    input  logic        resume,
    output logic        halted,
    output logic        trapped
);

    typedef enum logic [2:0] {
        S_FETCH_HI, S_FETCH_LO, S_DECODE, S_OPERAND,
        S_STORE, S_EXECUTE, S_HALT, S_TRAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc, r_inst;
    logic [7:0]  r_data, r_wdata;
    logic        r_rd, r_wr, r_exec, r_dec_en, r_halted, r_trapped;
    logic [15:0] w_pc_next;
    logic [15:0] w_addr;

    // Bit 15 of the opcode marks a 2-byte instruction; PC arithmetic wraps at 16 bits.
    assign w_pc_next = r_pc + (r_inst[15] ? 16'd2 : 16'd1);

    // Address mux: PC for opcode fetch, PC+1 for the low byte, operand address otherwise.
    always_comb begin
        w_addr = r_pc;
        case (r_state)
            S_FETCH_LO:       w_addr = r_pc + 16'd1;
            S_OPERAND, S_STORE: w_addr = opnd_addr;
            default:          w_addr = r_pc;
        endcase
    end

    // Control FSM; outputs are registered and set on the transition into each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH_HI;
            r_pc      <= RESET_PC;
            r_inst    <= 16'h0000;
            r_data    <= 8'h00;
            r_wdata   <= 8'h00;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_exec    <= 1'b0;
            r_dec_en  <= 1'b0;
            r_halted  <= 1'b0;
            r_trapped <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH_HI: begin
                    // r_rd is low only in the first cycle after reset; no access is pending then.
                    if (r_rd && mem_ready) begin
                        r_inst[15:8] <= mem_rdata;
                        if (mem_rdata[7]) begin
                            r_state <= S_FETCH_LO;
                        end else begin
                            r_inst[7:0] <= 8'h00;
                            r_state     <= S_DECODE;
                            r_rd        <= 1'b0;
                            r_dec_en    <= 1'b1;
                        end
                    end else begin
                        r_rd <= 1'b1;
                    end
                end
                S_FETCH_LO: begin
                    if (mem_ready) begin
                        r_inst[7:0] <= mem_rdata;
                        r_state     <= S_DECODE;
                        r_rd        <= 1'b0;
                        r_dec_en    <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_trap) begin
                        r_state   <= S_TRAP;
                        r_dec_en  <= 1'b0;
                        r_trapped <= 1'b1;
                    end else if (dec_halt) begin
                        // Resume continues after the halt instruction.
                        r_state  <= S_HALT;
                        r_dec_en <= 1'b0;
                        r_halted <= 1'b1;
                        r_pc     <= w_pc_next;
                    end else if (dec_store) begin
                        r_state <= S_STORE;
                        r_wr    <= 1'b1;
                        r_wdata <= store_data;
                    end else if (dec_mem) begin
                        r_state <= S_OPERAND;
                        r_rd    <= 1'b1;
                    end else begin
                        r_state <= S_EXECUTE;
                        r_exec  <= 1'b1;
                    end
                end
                S_OPERAND: begin
                    if (mem_ready) begin
                        r_data  <= mem_rdata;
                        r_rd    <= 1'b0;
                        r_state <= S_EXECUTE;
                        r_exec  <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (mem_ready) begin
                        r_wr    <= 1'b0;
                        r_state <= S_EXECUTE;
                        r_exec  <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    r_exec   <= 1'b0;
                    r_dec_en <= 1'b0;
                    r_pc     <= pc_load ? pc_target : w_pc_next;
                    r_state  <= S_FETCH_HI;
                    r_rd     <= 1'b1;
                end
                S_HALT: begin
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH_HI;
                        r_rd     <= 1'b1;
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH_HI;
                end
            endcase
        end
    end

    assign mem_addr  = w_addr;
    assign mem_rd    = r_rd;
    assign mem_wr    = r_wr;
    assign mem_wdata = r_wdata;
    assign inst      = r_inst;
    assign dec_en    = r_dec_en;
    assign data      = r_data;
    assign exec      = r_exec;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign trapped   = r_trapped;

endmodule

// File: tb/tb_cora16_sequencer.sv
// Directed bench for cora16_sequencer: byte memory with programmable wait
// states, decoder/datapath inputs driven per instruction.
module tb_cora16_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic [15:0] inst;
    logic        dec_en;
    logic [7:0]  data;
    logic        dec_halt = 1'b0, dec_trap = 1'b0, dec_mem = 1'b0, dec_store = 1'b0;
    logic [15:0] opnd_addr = 16'h0000;
    logic [7:0]  store_data = 8'h00;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic        exec;
    logic [15:0] pc;
    logic        resume = 1'b0;
    logic        halted, trapped;

    cora16_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .inst(inst), .dec_en(dec_en), .data(data),
        .dec_halt(dec_halt), .dec_trap(dec_trap), .dec_mem(dec_mem), .dec_store(dec_store),
        .opnd_addr(opnd_addr), .store_data(store_data),
        .pc_load(pc_load), .pc_target(pc_target),
        .exec(exec), .pc(pc), .resume(resume),
        .halted(halted), .trapped(trapped)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int waits = 0;
    int wcnt  = 0;
    int n_cmp = 0;
    int n_bad = 0;

    assign mem_rdata = mem[mem_addr];

    // Memory responder: mem_ready after 'waits' idle cycles of a pending access.
    always @(negedge clk) begin
        if (mem_ready) wcnt = 0;
        if ((mem_rd || mem_wr) && wcnt >= waits) begin
            mem_ready = 1'b1;
            if (mem_wr) mem[mem_addr] = mem_wdata;
        end else begin
            mem_ready = 1'b0;
            if (mem_rd || mem_wr) wcnt++;
            else wcnt = 0;
        end
    end

    // Read and write requests must never overlap.
    always @(negedge clk) begin
        if (mem_rd && mem_wr) chk("rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-instruction observations.
    logic [15:0] watch_addr;
    logic        saw_watch;
    int          wr_cycles;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  exec_data;

    task automatic sample();
        if (mem_rd && mem_addr == watch_addr) saw_watch = 1'b1;
        if (mem_wr) begin
            wr_cycles++;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
        end
    endtask

    // Called in the first FETCH_HI cycle; returns cycles up to and including exec.
    task automatic run_instr(input logic m, input logic st, input logic ld,
                             input logic [15:0] tgt, output int cyc);
        dec_mem = m; dec_store = st; pc_load = ld; pc_target = tgt;
        saw_watch = 1'b0; wr_cycles = 0; wr_addr = 16'h0; wr_data = 8'h0;
        cyc = 1;
        sample();
        while (!exec && cyc < 60) begin
            tick();
            cyc++;
            sample();
        end
        chk("exec_seen", 32'(exec), 32'd1);
        exec_data = data;
        tick();
        chk("exec_one_cycle", 32'(exec), 32'd0);
        dec_mem = 1'b0; dec_store = 1'b0; pc_load = 1'b0;
    endtask

    int cyc;
    int rd_cnt;
    logic found;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h07;
        mem[16'h0001] = 8'h06;
        mem[16'h0010] = 8'h88; mem[16'h0011] = 8'h05;
        mem[16'h0012] = 8'h90; mem[16'h0013] = 8'h11;
        mem[16'h4020] = 8'hA5;
        mem[16'h0014] = 8'hA0; mem[16'h0015] = 8'h22;
        mem[16'h0016] = 8'h05;
        mem[16'h0200] = 8'h06;
        mem[16'hFFFF] = 8'h80;
        mem[16'h0030] = 8'h01;
        mem[16'h0031] = 8'h02;
        watch_addr = 16'h0000;

        // Reset state.
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_inst", 32'(inst), 32'h0000);
        chk("rst_rd_wr", 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_flags", 32'({exec, dec_en, halted, trapped}), 32'd0);
        chk("rst_data_wdata", 32'({data, mem_wdata}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1-byte instruction 0x07 with zero wait states.
        tick();
        chk("t1_c1_rd", 32'(mem_rd), 32'd1);
        chk("t1_c1_addr", 32'(mem_addr), 32'h0000);
        tick();
        chk("t1_c2_inst", 32'(inst), 32'h0700);
        chk("t1_c2_dec_en_exec", 32'({dec_en, exec}), 32'b10);
        tick();
        chk("t1_c3_exec", 32'(exec), 32'd1);
        tick();
        chk("t1_pc", 32'(pc), 32'h0001);
        chk("t1_next_fetch", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'h0001});

        // Branch 0001 -> 0010.
        run_instr(1'b0, 1'b0, 1'b1, 16'h0010, cyc);
        chk("jmp10_pc", 32'(pc), 32'h0010);

        // 2-byte immediate with two wait states per fetch.
        waits = 2;
        run_instr(1'b0, 1'b0, 1'b0, 16'h0, cyc);
        waits = 0;
        chk("t2_cycles", 32'(cyc), 32'd8);
        chk("t2_inst", 32'(inst), 32'h8805);
        chk("t2_pc", 32'(pc), 32'h0012);
        chk("t2_data_untouched", 32'(data), 32'h00);

        // 2-byte RAM load.
        opnd_addr = 16'h4020;
        watch_addr = 16'h4020;
        run_instr(1'b1, 1'b0, 1'b0, 16'h0, cyc);
        chk("t3_cycles", 32'(cyc), 32'd5);
        chk("t3_rd_4020", 32'(saw_watch), 32'd1);
        chk("t3_data_at_exec", 32'(exec_data), 32'hA5);
        chk("t3_pc", 32'(pc), 32'h0014);

        // Store with one wait state on every access.
        opnd_addr = 16'h0100;
        store_data = 8'h3C;
        waits = 1;
        run_instr(1'b0, 1'b1, 1'b0, 16'h0, cyc);
        waits = 0;
        store_data = 8'h00;
        chk("t4_cycles", 32'(cyc), 32'd8);
        chk("t4_wr_cycles", 32'(wr_cycles), 32'd2);
        chk("t4_wr_addr", 32'(wr_addr), 32'h0100);
        chk("t4_wr_data", 32'(wr_data), 32'h3C);
        chk("t4_mem", 32'(mem[16'h0100]), 32'h3C);
        chk("t4_pc", 32'(pc), 32'h0016);
        chk("t4_data_held", 32'(data), 32'hA5);

        // Branch to 0200.
        run_instr(1'b0, 1'b0, 1'b1, 16'h0200, cyc);
        chk("br_cycles", 32'(cyc), 32'd3);
        chk("br_fetch", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'h0200});

        // Jump to FFFF, then 2-byte instruction straddling the wrap.
        run_instr(1'b0, 1'b0, 1'b1, 16'hFFFF, cyc);
        chk("wrap_start_pc", 32'(pc), 32'hFFFF);
        watch_addr = 16'h0000;
        run_instr(1'b0, 1'b0, 1'b0, 16'h0, cyc);
        chk("wrap_lo_at_0000", 32'(saw_watch), 32'd1);
        chk("wrap_inst", 32'(inst), 32'h8007);
        chk("wrap_pc", 32'(pc), 32'h0001);

        // Jump to 0030 where a halt sits.
        run_instr(1'b0, 1'b0, 1'b1, 16'h0030, cyc);
        chk("jmp30_pc", 32'(pc), 32'h0030);
        dec_halt = 1'b1;
        tick();
        tick();
        dec_halt = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'h0031);
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd || mem_wr) rd_cnt++;
            tick();
        end
        chk("halt_no_mem", 32'(rd_cnt), 32'd0);
        chk("halt_still", 32'(halted), 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_fetch", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'h0031});

        // Trap (with halt also decoded: trap has priority); resume ignored.
        dec_trap = 1'b1;
        dec_halt = 1'b1;
        tick();
        tick();
        dec_trap = 1'b0;
        dec_halt = 1'b0;
        chk("trap_flags", 32'({trapped, halted}), 32'b10);
        chk("trap_pc", 32'(pc), 32'h0031);
        resume = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        resume = 1'b0;
        chk("trap_sticky", 32'(trapped), 32'd1);
        chk("trap_pc_frozen", 32'(pc), 32'h0031);
        chk("trap_no_rd", 32'(mem_rd), 32'd0);

        // Async reset leaves TRAP, then reset in the middle of a FETCH_LO wait.
        mem[16'h0000] = 8'h81;
        waits = 3;
        rst = 1'b1;
        #1;
        chk("rst_clears_trap", 32'({trapped, pc}), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_rd && mem_addr == 16'h0001) found = 1'b1;
        end
        chk("lo_fetch_reached", 32'(found), 32'd1);
        tick();
        chk("lo_still_waiting", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'h0001});
        rst = 1'b1;
        #1;
        chk("midrst_rd", 32'(mem_rd), 32'd0);
        chk("midrst_pc_addr", 32'({pc, mem_addr}), 32'h0);
        chk("midrst_inst", 32'(inst), 32'h0000);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
